// File: rtl/tone_mixer_i2s.sv
// Multi-voice triangle tone generator with an I2S master transmitter.
// Each voice runs a phase accumulator; voices are summed with saturation
// and the mono mix is sent on both I2S channels (Philips framing).
module tone_mixer_i2s #(
  parameter int N_CH     = 3,
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         gate,
  input  logic [N_CH*PHASE_W-1:0] phase_inc,
  output logic                    aud_bclk,
  output logic                    aud_daclrck,
  output logic                    aud_dacdat,
  output logic                    sample_strobe,
  output logic [N_CH-1:0]         active
);

  localparam int W      = SAMPLE_W;
  localparam int SLOT_W = $clog2(2*W);
  localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SUM_W  = W + $clog2(N_CH) + 1;

  localparam logic [SLOT_W-1:0]        SLOT_LAST = SLOT_W'(2*W-1);
  localparam logic [SLOT_W-1:0]        SLOT_HALF = SLOT_W'(W);
  localparam logic [DIV_W-1:0]         DIV_LAST  = DIV_W'(BCLK_DIV-1);
  localparam logic [PHASE_W-1:0]       QUARTER   = {2'b01, {(PHASE_W-2){1'b0}}};
  localparam logic signed [SUM_W-1:0]  SAT_HI    = {{(SUM_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]  SAT_LO    = {{(SUM_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_REL  = 2'd2
  } voice_state_t;

  logic [DIV_W-1:0]        r_div;
  logic                    r_bclk;
  logic [SLOT_W-1:0]       r_slot;
  logic                    r_lrck;
  logic                    r_dat;
  logic                    r_strobe;
  logic [2*W-1:0]          r_frame;
  logic [N_CH-1:0]         r_active;

  logic                    w_bclk_fall;
  logic                    w_frame_start;
  logic [SLOT_W-1:0]       w_slot_nxt;
  logic [SLOT_W-1:0]       w_bit_idx;
  logic                    w_dat_nxt;
  logic [N_CH*W-1:0]       w_tri_bus;
  logic [N_CH-1:0]         w_active_nxt;
  logic signed [SUM_W-1:0] w_acc;
  logic [W-1:0]            w_mix;

  // BCLK divider: toggle the bit clock every BCLK_DIV system clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= {DIV_W{1'b0}};
      r_bclk <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div  <= {DIV_W{1'b0}};
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Slot advance and the serial bit that belongs to the upcoming slot.
  always_comb begin
    w_bclk_fall = (r_div == DIV_LAST) && r_bclk;
    if (r_slot == SLOT_LAST) begin
      w_slot_nxt = {SLOT_W{1'b0}};
    end else begin
      w_slot_nxt = r_slot + SLOT_W'(1);
    end
    w_frame_start = w_bclk_fall && (r_slot == SLOT_LAST);
    // slot s (s >= 1) carries bit 2W-s, i.e. (2W-1) - (s-1)
    w_bit_idx = SLOT_LAST - (w_slot_nxt - SLOT_W'(1));
    if (w_slot_nxt == {SLOT_W{1'b0}}) begin
      w_dat_nxt = r_frame[0];
    end else begin
      w_dat_nxt = r_frame[w_bit_idx];
    end
  end

  // Slot counter, word select, serial data and frame-start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= SLOT_LAST;
      r_lrck   <= 1'b1;
      r_dat    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_frame_start;
      if (w_bclk_fall) begin
        r_slot <= w_slot_nxt;
        r_lrck <= (w_slot_nxt >= SLOT_HALF);
        r_dat  <= w_dat_nxt;
      end
    end
  end

  // Latch the mix into both channels during slot 0, before the MSB goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= {(2*W){1'b0}};
    end else if (r_strobe) begin
      r_frame <= {w_mix, w_mix};
    end
  end

  // Voice activity flags follow the voice states after each strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= {N_CH{1'b0}};
    end else if (r_strobe) begin
      r_active <= w_active_nxt;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_voice
    voice_state_t       r_state;
    voice_state_t       w_state_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [PHASE_W-1:0] w_inc;
    logic [PHASE_W:0]   w_sum;
    logic [PHASE_W-1:0] w_q;
    logic [W:0]         w_p;
    logic [W-1:0]       w_u;
    logic [W-1:0]       w_tri;
    logic               w_unused_low;

    assign w_inc = phase_inc[gi*PHASE_W +: PHASE_W];
    assign w_sum = {1'b0, r_phase} + {1'b0, w_inc};

    // Voice next state: IDLE/RUN/RELEASE, only moves on a frame strobe.
    always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      if (r_strobe) begin
        case (r_state)
          S_IDLE: begin
            if (gate[gi]) begin
              w_state_nxt = S_RUN;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          S_RUN: begin
            w_phase_nxt = w_sum[PHASE_W-1:0];
            if (!gate[gi]) begin
              w_state_nxt = S_REL;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
          S_REL: begin
            if (gate[gi]) begin
              w_state_nxt = S_RUN;
              w_phase_nxt = w_sum[PHASE_W-1:0];
            end else if ((w_inc == {PHASE_W{1'b0}}) || w_sum[PHASE_W]) begin
              // release ends at the phase wrap so note-off does not click
              w_state_nxt = S_IDLE;
              w_phase_nxt = {PHASE_W{1'b0}};
            end else begin
              w_state_nxt = S_REL;
              w_phase_nxt = w_sum[PHASE_W-1:0];
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = {PHASE_W{1'b0}};
          end
        endcase
      end else begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
      end
    end

    // Voice state and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_phase <= {PHASE_W{1'b0}};
      end else begin
        r_state <= w_state_nxt;
        r_phase <= w_phase_nxt;
      end
    end

    // Triangle from phase: quarter offset makes phase 0 map to sample 0.
    always_comb begin
      w_q = r_phase + QUARTER;
      w_p = w_q[PHASE_W-1 -: W+1];
      if (w_p[W]) begin
        w_u = ~w_p[W-1:0];
      end else begin
        w_u = w_p[W-1:0];
      end
      if (r_state == S_IDLE) begin
        w_tri = {W{1'b0}};
      end else begin
        w_tri = {~w_u[W-1], w_u[W-2:0]};
      end
    end

    assign w_unused_low          = ^w_q[PHASE_W-W-2:0];
    assign w_tri_bus[gi*W +: W]  = w_tri;
    assign w_active_nxt[gi]      = (w_state_nxt != S_IDLE);
  end

  // Full-width signed sum of the voices, then clamp to the sample range.
  always_comb begin
    w_acc = {SUM_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      w_acc = w_acc + SUM_W'($signed(w_tri_bus[i*W +: W]));
    end
    if (w_acc > SAT_HI) begin
      w_mix = SAT_HI[W-1:0];
    end else if (w_acc < SAT_LO) begin
      w_mix = SAT_LO[W-1:0];
    end else begin
      w_mix = w_acc[W-1:0];
    end
  end

  assign aud_bclk      = r_bclk;
  assign aud_daclrck   = r_lrck;
  assign aud_dacdat    = r_dat;
  assign sample_strobe = r_strobe;
  assign active        = r_active;

endmodule
